// File: rtl/vidmem_write_controller_pkg.sv
// vidmem_write_controller_pkg: text geometry, opcodes and command record for the video memory write sequencer
package vidmem_write_controller_pkg;
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int COL_W = 8;
  localparam int ROW_W = 6;
  localparam int VAL_W = 16;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    VCMD_NOP = 3'd0,
    VCMD_PUTCHAR = 3'd1,
    VCMD_GOTO = 3'd2,
    VCMD_NEWLINE = 3'd3,
    VCMD_CLEAR_SCREEN = 3'd4,
    VCMD_CLEAR_EOL = 3'd5
  } vcmd_t;
  typedef enum logic {IDLE, FILL} state_t;
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [COL_W-1:0] x;
    logic [ROW_W-1:0] y;
    logic [VAL_W-1:0] value;
  } cmd_t;
endpackage

// File: rtl/vidmem_write_controller_if.sv
// vidmem_write_controller_if: terminal command handshake between host decoder and write sequencer
interface vidmem_write_controller_if;
  import vidmem_write_controller_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [COL_W-1:0] cmd_x;
  logic [ROW_W-1:0] cmd_y;
  logic [VAL_W-1:0] cmd_value;
  modport master (output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_value, input cmd_ready);
  modport slave (input cmd_valid, cmd_op, cmd_x, cmd_y, cmd_value, output cmd_ready);
endinterface

// File: rtl/vidmem_cmd_fifo.sv
// vidmem_cmd_fifo: generic synchronous FIFO; a push into a full FIFO succeeds when a pop happens on the same edge
module vidmem_cmd_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp == AW'(DEPTH-1) ? '0 : wp + 1'b1;
      end
      if (do_pop) rp <= rp == AW'(DEPTH-1) ? '0 : rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/vidmem_write_controller.sv
// vidmem_write_controller: turns terminal commands into single-cell video memory writes; VIDMEM_CMD_FIFO_EN adds a 4-deep command FIFO
module vidmem_write_controller
  import vidmem_write_controller_pkg::*;
#(
  parameter int COLS = TEXT_COLS,
  parameter int ROWS = TEXT_ROWS
) (
  input  logic clk,
  input  logic reset,
  vidmem_write_controller_if.slave cmd,
  output logic write,
  output logic [COL_W-1:0] xtextwrite,
  output logic [ROW_W-1:0] ytextwrite,
  output logic [VAL_W-1:0] value,
  output logic [COL_W-1:0] cursor_x,
  output logic [ROW_W-1:0] cursor_y,
  output logic busy
);
  localparam logic [COL_W-1:0] XMAX = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0] YMAX = ROW_W'(ROWS-1);
  state_t state, state_n;
  logic eol, eol_n, write_n, idle, last, s_valid;
  logic [COL_W-1:0] xw_n, cx_n;
  logic [ROW_W-1:0] yw_n, cy_n;
  logic [VAL_W-1:0] val_n;
  cmd_t s_cmd;
  assign idle = state == IDLE;
  assign busy = !idle;
`ifdef VIDMEM_CMD_FIFO_EN
  logic full, empty;
  assign cmd.cmd_ready = !full && !reset;
  assign s_valid = !empty;
  vidmem_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(4)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(cmd.cmd_valid && cmd.cmd_ready),
    .pop(idle),
    .din({cmd.cmd_op, cmd.cmd_x, cmd.cmd_y, cmd.cmd_value}),
    .dout(s_cmd),
    .full(full),
    .empty(empty)
  );
`else
  assign cmd.cmd_ready = idle && !reset;
  assign s_valid = cmd.cmd_valid;
  assign s_cmd = {cmd.cmd_op, cmd.cmd_x, cmd.cmd_y, cmd.cmd_value};
`endif
  // the write address registers double as the fill walker
  assign last = xtextwrite == XMAX && (eol || ytextwrite == YMAX);
  always_comb begin
    state_n = state;
    write_n = 1'b0;
    xw_n = xtextwrite;
    yw_n = ytextwrite;
    val_n = value;
    eol_n = eol;
    cx_n = cursor_x;
    cy_n = cursor_y;
    if (!idle) begin
      if (last) state_n = IDLE;
      else begin
        write_n = 1'b1;
        xw_n = xtextwrite == XMAX ? '0 : xtextwrite + 1'b1;
        yw_n = xtextwrite == XMAX ? ytextwrite + 1'b1 : ytextwrite;
      end
    end else if (s_valid) begin
      case (s_cmd.op)
        VCMD_PUTCHAR: begin
          write_n = 1'b1;
          xw_n = cursor_x;
          yw_n = cursor_y;
          val_n = s_cmd.value;
          cx_n = cursor_x == XMAX ? '0 : cursor_x + 1'b1;
          cy_n = cursor_x != XMAX ? cursor_y : cursor_y == YMAX ? '0 : cursor_y + 1'b1;
        end
        VCMD_GOTO: begin
          cx_n = s_cmd.x > XMAX ? XMAX : s_cmd.x;
          cy_n = s_cmd.y > YMAX ? YMAX : s_cmd.y;
        end
        VCMD_NEWLINE: begin
          cx_n = '0;
          cy_n = cursor_y == YMAX ? '0 : cursor_y + 1'b1;
        end
        VCMD_CLEAR_SCREEN: begin
          state_n = FILL;
          write_n = 1'b1;
          xw_n = '0;
          yw_n = '0;
          val_n = s_cmd.value;
          eol_n = 1'b0;
          cx_n = '0;
          cy_n = '0;
        end
        VCMD_CLEAR_EOL: begin
          state_n = FILL;
          write_n = 1'b1;
          xw_n = cursor_x;
          yw_n = cursor_y;
          val_n = s_cmd.value;
          eol_n = 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      write <= 1'b0;
      xtextwrite <= '0;
      ytextwrite <= '0;
      value <= '0;
      eol <= 1'b0;
      cursor_x <= '0;
      cursor_y <= '0;
    end else begin
      state <= state_n;
      write <= write_n;
      xtextwrite <= xw_n;
      ytextwrite <= yw_n;
      value <= val_n;
      eol <= eol_n;
      cursor_x <= cx_n;
      cursor_y <= cy_n;
    end
  end
endmodule

// File: tb/tb_vidmem_write_controller.sv
// tb_vidmem_write_controller: directed and random commands checked against a cell-list reference model
module tb_vidmem_write_controller;
  import vidmem_write_controller_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic write, busy;
  logic [7:0] xtextwrite, cursor_x;
  logic [5:0] ytextwrite, cursor_y;
  logic [15:0] value;
  int n_assert = 0, n_fail = 0;
  int mx = 0, my = 0;
  logic [29:0] exp_q[$];
  logic [29:0] obs_q[$];
  vidmem_write_controller_if bus();
  vidmem_write_controller dut (
    .clk(clk), .reset(reset), .cmd(bus), .write(write), .xtextwrite(xtextwrite),
    .ytextwrite(ytextwrite), .value(value), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (write) obs_q.push_back({xtextwrite, ytextwrite, value});
  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic model(input int op, input int x, input int y, input logic [15:0] v);
    case (op)
      1: begin
        exp_q.push_back({8'(mx), 6'(my), v});
        if (mx < TEXT_COLS - 1) mx++;
        else begin
          mx = 0;
          my = (my + 1) % TEXT_ROWS;
        end
      end
      2: begin
        mx = x < TEXT_COLS ? x : TEXT_COLS - 1;
        my = y < TEXT_ROWS ? y : TEXT_ROWS - 1;
      end
      3: begin
        mx = 0;
        my = (my + 1) % TEXT_ROWS;
      end
      4: begin
        for (int yy = 0; yy < TEXT_ROWS; yy++)
          for (int xx = 0; xx < TEXT_COLS; xx++) exp_q.push_back({8'(xx), 6'(yy), v});
        mx = 0;
        my = 0;
      end
      5: for (int xx = mx; xx < TEXT_COLS; xx++) exp_q.push_back({8'(xx), 6'(my), v});
      default: ;
    endcase
  endtask
  task automatic send(input int op, input int x, input int y, input logic [15:0] v);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, n < 5000}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'(op);
    bus.cmd_x = 8'(x);
    bus.cmd_y = 6'(y);
    bus.cmd_value = v;
    model(op, x, y, v);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic fill_watch(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (write !== 1'b1 || bus.cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    check({tag, "_bad_cycles"}, bad, 0);
    check({tag, "_ready_after"}, {31'd0, bus.cmd_ready}, 32'd1);
    check({tag, "_write_after"}, {31'd0, write}, 32'd0);
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (!(bus.cmd_ready === 1'b1 && write === 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_cell"}, {2'd0, obs_q[i]}, {2'd0, exp_q[i]});
    check({tag, "_cursor_x"}, {24'd0, cursor_x}, mx);
    check({tag, "_cursor_y"}, {26'd0, cursor_y}, my);
    obs_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int op;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_write", {31'd0, write}, 0);
    check("rst_xw", {24'd0, xtextwrite}, 0);
    check("rst_yw", {26'd0, ytextwrite}, 0);
    check("rst_value", {16'd0, value}, 0);
    check("rst_cx", {24'd0, cursor_x}, 0);
    check("rst_cy", {26'd0, cursor_y}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, bus.cmd_ready}, 0);
    reset = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd1;
    bus.cmd_value = 16'h0741;
    model(1, 0, 0, 16'h0741);
    @(posedge clk);
    #1;
    check("putc_write", {31'd0, write}, 1);
    check("putc_xw", {24'd0, xtextwrite}, 0);
    check("putc_yw", {26'd0, ytextwrite}, 0);
    check("putc_value", {16'd0, value}, 32'h0741);
    check("putc_cx", {24'd0, cursor_x}, 1);
    check("putc_cy", {26'd0, cursor_y}, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    drain("putc_a");
    send(2, 79, 29, 16'h0);
    send(1, 0, 0, 16'h0742);
    send(1, 0, 0, 16'h0743);
    drain("wrap");
    send(2, 200, 50, 16'h0);
    drain("clamp");
    send(4, 0, 0, 16'h1f20);
    bus.cmd_value = 16'hdead;
    fill_watch("cls", 2400);
    drain("cls");
    send(2, 75, 3, 16'h0);
    send(5, 0, 0, 16'h2e2d);
    bus.cmd_value = 16'hbeef;
    fill_watch("eol", 5);
    drain("eol");
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 7));
      if (op == 4 && $urandom_range(0, 3) != 0) op = 1;
      send(op, int'($urandom_range(0, 255)), int'($urandom_range(0, 63)), 16'($urandom));
      bus.cmd_value = 16'($urandom);
      bus.cmd_op = 3'($urandom);
      if (i % 10 == 9) drain("rand");
    end
    drain("rand_end");
    send(2, 10, 7, 16'h0);
    drain("pre_rst");
    send(4, 0, 0, 16'h0a0b);
    repeat (99) @(negedge clk);
    check("fill_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_write", {31'd0, write}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_cx", {24'd0, cursor_x}, 0);
    check("abort_cy", {26'd0, cursor_y}, 0);
    check("abort_ready", {31'd0, bus.cmd_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    mx = 0;
    my = 0;
    send(1, 0, 0, 16'h0758);
    drain("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
